// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Optional statistics counters are enabled with ALU_SEQ_STATS_EN.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int FLG_GT = 2;
  localparam int FLG_EQ = 1;
  localparam int FLG_LT = 0;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    RESPOND
  } state_e;

endpackage

// File: rtl/alu_rsp_format.sv
// Combinational normalisation of raw ALU outputs into response data/flags.
// Undriven bit 4 of the subtract and AND results is masked here.
module alu_rsp_format
  import alu_seq_pkg::*;
(
  input  logic [1:0] op,
  input  logic [4:0] alu_result1,
  input  logic [4:0] alu_result2,
  input  logic       alu_equal,
  input  logic       alu_greater,
  input  logic       alu_lesser,
  input  logic [4:0] alu_result4,
  output logic [4:0] data,
  output logic [2:0] flags
);

  logic unused_hi;
  assign unused_hi = alu_result2[4] ^ alu_result4[4];

  always_comb begin
    data  = '0;
    flags = '0;
    unique case (1'b1)
      op == OP_ADD: data = alu_result1;
      op == OP_SUB: data = {1'b0, alu_result2[3:0]};
      op == OP_CMP: begin
        flags[FLG_GT] = alu_greater;
        flags[FLG_EQ] = alu_equal;
        flags[FLG_LT] = alu_lesser;
      end
      op == OP_AND: data = {1'b0, alu_result4[3:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response front end for the 4-bit four-function ALU.
// Define ALU_SEQ_STATS_EN to add saturating stat_ops/stat_carry counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic       alu_select0,
  output logic       alu_select1,
  output logic [3:0] alu_bit1,
  output logic [3:0] alu_bit2,
  input  logic [4:0] alu_result1,
  input  logic [4:0] alu_result2,
  input  logic       alu_equal,
  input  logic       alu_greater,
  input  logic       alu_lesser,
  input  logic [4:0] alu_result4,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_op,
  output logic [4:0] rsp_data,
  output logic [2:0] rsp_flags
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0] stat_ops,
  output logic [7:0] stat_carry
`endif
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q;
  logic [3:0] a_q, b_q;
  logic       rsp_valid_q;
  logic [1:0] rsp_op_q;
  logic [4:0] rsp_data_q;
  logic [2:0] rsp_flags_q;

  logic       accept;
  logic       rsp_hs;
  logic       driving;
  logic [4:0] fmt_data;
  logic [2:0] fmt_flags;

  // cmd_ready is gated by rst so it reads 0 while reset is held
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign driving   = (state_q == DRIVE) ||
                     (state_q == CAPTURE);

  assign alu_select0 = driving ? op_q[0] : 1'b0;
  assign alu_select1 = driving ? op_q[1] : 1'b0;
  assign alu_bit1    = driving ? a_q : 4'd0;
  assign alu_bit2    = driving ? b_q : 4'd0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;

  alu_rsp_format u_fmt (
    .op          (op_q),
    .alu_result1 (alu_result1),
    .alu_result2 (alu_result2),
    .alu_equal   (alu_equal),
    .alu_greater (alu_greater),
    .alu_lesser  (alu_lesser),
    .alu_result4 (alu_result4),
    .data        (fmt_data),
    .flags       (fmt_flags)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      state_q == IDLE: begin
        cnt_d = '0;
        if (accept) state_d = DRIVE;
      end
      state_q == DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      state_q == CAPTURE: state_d = RESPOND;
      state_q == RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q <= cmd_op;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      if (state_q == CAPTURE) begin
        rsp_valid_q <= 1'b1;
        rsp_op_q    <= op_q;
        rsp_data_q  <= fmt_data;
        rsp_flags_q <= fmt_flags;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] stat_ops_q, stat_carry_q;

  assign stat_ops   = stat_ops_q;
  assign stat_carry = stat_carry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q   <= '0;
      stat_carry_q <= '0;
    end else if (rsp_hs) begin
      if (stat_ops_q != 8'hFF)
        stat_ops_q <= stat_ops_q + 8'd1;
      if (rsp_op_q == OP_ADD && rsp_data_q[4] &&
          stat_carry_q != 8'hFF)
        stat_carry_q <= stat_carry_q + 8'd1;
    end
  end
`endif

endmodule
